// File: rtl/spi_master_xfer_if.sv
// spi_master_xfer_if: host handshake and SPI pin bundle for spi_master_xfer
// Signals: start/tx_data/hold_cs request a byte; busy/done/rx_data report it;
// sck/mosi/cs_n/miso are the SPI mode-0 pins.
// modport master is the SPI master side; modport slave is the host/peripheral side.
`timescale 1ns/1ps
interface spi_master_xfer_if;
  logic       start;
  logic [7:0] tx_data;
  logic       hold_cs;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  modport master (
    input  start, tx_data, hold_cs, miso,
    output busy, done, rx_data, sck, mosi, cs_n
  );
  modport slave (
    output start, tx_data, hold_cs, miso,
    input  busy, done, rx_data, sck, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_xfer.sv
// spi_master_xfer: single-byte SPI mode-0 master, MSB first, optional chip-select hold
// Ports: clk; reset (async, active low); bus (spi_master_xfer_if.master):
//   start/tx_data/hold_cs in, busy/done/rx_data out, sck/mosi/cs_n out, miso in.
// Parameter HALF: clk cycles per SCK half-period (2..255, 3..255 with sync).
// Macro SPI_MASTER_MISO_SYNC_EN: miso through a two-flop synchronizer, captured
//   two cycles after each sck rise; otherwise raw miso is captured on the rise cycle.
`timescale 1ns/1ps
module spi_master_xfer #(
  parameter int HALF = 4
) (
  input logic          clk,
  input logic          reset,
  spi_master_xfer_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, CS_HOLD} state_t;
  localparam logic [7:0] LAST = 8'(HALF - 1);
  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_sh, tx_d;
  logic [7:0] rx_sh, rx_d;
  logic [7:0] rx_out, rx_out_d;
  logic       sck, sck_d;
  logic       mosi, mosi_d;
  logic       csn, csn_d;
  logic       busy, busy_d;
  logic       done, done_d;
  logic       hold, hold_d;
  logic       expire;
  logic       cap;
  logic       rx_bit;
  assign expire = cnt == 8'd0;
`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else        sync <= {sync[0], bus.miso};
  assign rx_bit = sync[1];
  assign cap    = state == HIGH && cnt == 8'(HALF - 3);
`else
  assign rx_bit = bus.miso;
  assign cap    = state == HIGH && cnt == LAST;
`endif
  always_comb begin
    state_d  = state;
    cnt_d    = expire ? LAST : cnt - 8'd1;
    bit_d    = bit_q;
    tx_d     = tx_sh;
    rx_d     = cap ? {rx_sh[6:0], rx_bit} : rx_sh;
    rx_out_d = rx_out;
    sck_d    = sck;
    mosi_d   = mosi;
    csn_d    = csn;
    busy_d   = busy;
    done_d   = 1'b0;
    hold_d   = hold;
    case (state)
      IDLE: begin
        cnt_d = LAST;
        // the done cycle itself never accepts a new start
        if (bus.start && !done) begin
          state_d = SETUP;
          bit_d   = 3'd0;
          tx_d    = bus.tx_data;
          mosi_d  = bus.tx_data[7];
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          hold_d  = bus.hold_cs;
        end
      end
      SETUP, LOW: begin
        if (expire) begin
          state_d = HIGH;
          sck_d   = 1'b1;
        end
      end
      HIGH: begin
        if (expire) begin
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            if (hold) begin
              state_d  = IDLE;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              rx_out_d = rx_d;
            end else begin
              state_d = CS_HOLD;
            end
          end else begin
            state_d = LOW;
            bit_d   = bit_q + 3'd1;
            mosi_d  = tx_sh[6];
            tx_d    = {tx_sh[6:0], 1'b0};
          end
        end
      end
      CS_HOLD: begin
        if (expire) begin
          state_d  = IDLE;
          csn_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          rx_out_d = rx_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bit_q  <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rx_out <= '0;
      sck    <= 1'b0;
      mosi   <= 1'b0;
      csn    <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      hold   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      bit_q  <= bit_d;
      tx_sh  <= tx_d;
      rx_sh  <= rx_d;
      rx_out <= rx_out_d;
      sck    <= sck_d;
      mosi   <= mosi_d;
      csn    <= csn_d;
      busy   <= busy_d;
      done   <= done_d;
      hold   <= hold_d;
    end
  assign bus.sck     = sck;
  assign bus.mosi    = mosi;
  assign bus.cs_n    = csn;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rx_data = rx_out;
endmodule

// File: tb/tb_spi_master_xfer.sv
// tb_spi_master_xfer: scoreboard bench for spi_master_xfer at HALF=4, 2 (3 with sync) and 3
`timescale 1ns/1ps
module tb_spi_master_xfer;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int H1 = 3;
`else
  localparam int H1 = 2;
`endif
  typedef struct {
    int         g;
    logic [7:0] tx;
    logic [7:0] rx;
    int         cyc;
    logic       csn;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sbq [$];
  logic       st [3];
  logic       hd [3];
  logic       ld [3];
  logic       dn [3];
  logic [7:0] td [3];
  logic [7:0] sl [3];
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  function automatic int hs(input int g);
    return g == 0 ? 4 : (g == 1 ? H1 : 3);
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int H = g == 0 ? 4 : (g == 1 ? H1 : 3);
    spi_master_xfer_if bus ();
    spi_master_xfer #(.HALF(H)) dut (.clk(clk), .reset(rst), .bus(bus));
    logic [7:0] sr;
    logic       sq;
    assign bus.start   = st[g];
    assign bus.tx_data = td[g];
    assign bus.hold_cs = hd[g];
    assign bus.miso    = sr[7];
    assign dn[g]       = bus.done;
    // mode-0 slave: first bit ready before the first rise, next bit after each fall
    always @(posedge clk) begin
      sq <= bus.sck;
      if (ld[g]) sr <= sl[g];
      else if (sq && !bus.sck) sr <= {sr[6:0], 1'b0};
    end
    initial begin : mon
      int         rises;
      logic [7:0] mb;
      logic       sp;
      exp_t       e;
      rises = 0;
      mb = '0;
      sp = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          rises = 0;
          sp = 1'b0;
        end else begin
          if (bus.sck && !sp) begin
            rises++;
            mb = {mb[6:0], bus.mosi};
          end
          sp = bus.sck;
          if (bus.busy) chk($sformatf("cs_low_busy%0d", g), bus.cs_n, 0);
          if (bus.done) begin
            if (sbq.size() == 0) begin
              chk($sformatf("unexpected_done%0d", g), sbq.size(), 1);
            end else begin
              e = sbq.pop_front();
              chk("done_inst", g, e.g);
              chk($sformatf("rx_data%0d", g), bus.rx_data, e.rx);
              chk($sformatf("done_cycle%0d", g), cyc, e.cyc);
              chk($sformatf("cs_n_at_done%0d", g), bus.cs_n, e.csn);
              chk($sformatf("sck_rises%0d", g), rises, 8);
              chk($sformatf("mosi_bits%0d", g), mb, e.tx);
              chk($sformatf("busy_at_done%0d", g), bus.busy, 0);
            end
            rises = 0;
          end
        end
      end
    end
  end
  task automatic issue(input int g, input logic [7:0] t, input logic [7:0] s,
                       input logic h, input bit push);
    st[g] = 1'b1;
    td[g] = t;
    hd[g] = h;
    sl[g] = s;
    ld[g] = 1'b1;
    if (push) sbq.push_back('{g, t, s, cyc + 1 + (h ? 16 : 17) * hs(g), ~h});
    @(posedge clk);
    #1;
    st[g] = 1'b0;
    ld[g] = 1'b0;
  endtask
  task automatic wait_done(input int g);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (dn[g]) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout%0d: done not seen, required within 3000 cycles", g);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      hd[i] = 1'b0;
      ld[i] = 1'b0;
      td[i] = '0;
      sl[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", u[0].bus.sck, 0);
    chk("rst_mosi", u[0].bus.mosi, 0);
    chk("rst_cs_n", u[0].bus.cs_n, 1);
    chk("rst_busy", u[0].bus.busy, 0);
    chk("rst_done", u[0].bus.done, 0);
    chk("rst_rx", u[0].bus.rx_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 8'hA5, 8'h3C, 1'b0, 1'b1);
    chk("busy_cycle1", u[0].bus.busy, 1);
    chk("mosi_cycle1", u[0].bus.mosi, 1);
    chk("cs_cycle1", u[0].bus.cs_n, 0);
    wait_done(0);
    repeat (4) @(posedge clk);
    #1;
    chk("mosi_hold", u[0].bus.mosi, 1);
    chk("cs_released", u[0].bus.cs_n, 1);
    issue(1, 8'h03, 8'h5A, 1'b1, 1'b1);
    wait_done(1);
    // start held through the done cycle: only the following edge may accept it
    st[1] = 1'b1;
    td[1] = 8'hFF;
    hd[1] = 1'b1;
    sl[1] = 8'hC3;
    ld[1] = 1'b1;
    sbq.push_back('{1, 8'hFF, 8'hC3, cyc + 2 + 16 * hs(1), 1'b0});
    @(posedge clk);
    #1;
    chk("cs_gap_low", u[1].bus.cs_n, 0);
    chk("busy_after_done", u[1].bus.busy, 0);
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    ld[1] = 1'b0;
    chk("busy_second", u[1].bus.busy, 1);
    wait_done(1);
    @(posedge clk);
    #1;
    chk("cs_still_low", u[1].bus.cs_n, 0);
    issue(1, 8'h5A, 8'h0F, 1'b0, 1'b1);
    wait_done(1);
    @(posedge clk);
    #1;
    chk("cs_release_hold", u[1].bus.cs_n, 1);
    issue(0, 8'h96, 8'h69, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    st[0] = 1'b1;
    td[0] = 8'h00;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    st[0] = 1'b1;
    hd[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    wait_done(0);
    repeat (80) @(posedge clk);
    #1;
    issue(0, 8'h55, 8'hAA, 1'b0, 1'b0);
    repeat (29) @(posedge clk);
    #2;
    chk("pre_rst_sck_high", u[0].bus.sck, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_sck", u[0].bus.sck, 0);
    chk("mid_rst_cs_n", u[0].bus.cs_n, 1);
    chk("mid_rst_busy", u[0].bus.busy, 0);
    chk("mid_rst_mosi", u[0].bus.mosi, 0);
    chk("mid_rst_rx", u[0].bus.rx_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 8'hC6, 8'h2B, 1'b0, 1'b1);
    wait_done(0);
    @(posedge clk);
    #1;
    issue(2, 8'h81, 8'h81, 1'b0, 1'b1);
    wait_done(2);
    repeat (10) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_xfer.md
SPI_MASTER_XFER -- requirements
Module: spi_master_xfer

Interface
REQ-001 Parameter HALF, default 4, SHALL set clk cycles per SCK half-period; legal range 2..255 (3..255 when SPI_MASTER_MISO_SYNC_EN is defined).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request one byte transfer; it is sampled only when busy=0.
REQ-005 tx_data  input  8  SHALL be the byte to send, MSB first, latched on the accepted start.
REQ-006 hold_cs  input  1  SHALL be latched with start; 1 keeps cs_n low after the byte, 0 releases it.
REQ-007 busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking transfer completion.
REQ-009 rx_data  output  8  SHALL hold the last received byte, MSB first, valid from the done cycle until the next done.
REQ-010 sck  output  1  SHALL be the SPI clock, mode 0 (idle low, sample on rise, shift on fall).
REQ-011 mosi  output  1  SHALL be the serial data out.
REQ-012 miso  input  1  SHALL be the serial data in.
REQ-013 cs_n  output  1  SHALL be the active-low chip select.

Function
REQ-014 States SHALL be IDLE, SETUP, HIGH, LOW, CS_HOLD; one down-counter SHALL time every phase in HALF-cycle units, and a 3-bit counter SHALL count bits.
REQ-015 start=1 in IDLE at cycle 0 SHALL load the shift register, set busy=1, drive cs_n=0 and mosi=tx_data[7] at cycle 1, and enter SETUP.
REQ-016 If cs_n is already low from a previous hold_cs=1 byte, SETUP SHALL still last HALF cycles, so the timing in REQ-017 is unchanged.
REQ-017 Bit n (n=0..7) SHALL raise sck at cycle 1+(2n+1)*HALF and lower it at cycle 1+(2n+2)*HALF.
REQ-018 On each sck rise, the receiver SHALL shift miso into the LSB of the receive register.
REQ-019 On each sck fall except the 8th, mosi SHALL advance to the next lower tx bit.
REQ-020 hold_cs=1: at cycle 1+16*HALF, done=1, busy=0, rx_data updated, cs_n stays 0, sck=0, and state returns to IDLE.
REQ-021 hold_cs=0: after the 8th fall, the block SHALL enter CS_HOLD for HALF cycles; at cycle 1+17*HALF, cs_n=1, done=1, busy=0, and rx_data updated.
REQ-022 start while busy=1 SHALL be ignored, with no latching and no error.
REQ-023 start on the done cycle SHALL be ignored; start is accepted from the cycle after done.
REQ-024 mosi SHALL hold its last value between transfers, and sck SHALL never glitch; sck, mosi and cs_n SHALL be registered outputs.
REQ-025 The bit counter SHALL wrap 7->0 only on completion, with no extra sck edges.

Reset
REQ-026 Asserting reset (low) SHALL immediately force sck=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0 and state=IDLE, including in the middle of a transfer.
REQ-027 After reset is released, the first posedge clk with start=1 SHALL begin a transfer per REQ-015; no partial byte SHALL resume.

Configuration
REQ-028 Macro SPI_MASTER_MISO_SYNC_EN SHALL select the miso capture path.
- Defined: miso passes through a two-flop synchronizer, and capture occurs 2 cycles after each sck rise (still before the fall, hence HALF>=3).
- Undefined: raw miso is captured on the sck-rise cycle.
- Output timing (sck, mosi, cs_n, done) is identical in both builds.

Verification
REQ-029 HALF=4, hold_cs=0, tx_data=8'hA5, miso driven from an 8'h3C slave model -> mosi bits 1,0,1,0,0,1,0,1; 8 sck pulses; done at cycle 69; rx_data=8'h3C; cs_n=1 at cycle 69.
REQ-030 HALF=2, hold_cs=1, bytes 8'h03 then 8'hFF, second start issued the cycle after the first done -> cs_n stays low across both bytes; first done at cycle 33; then hold_cs=0 releases cs_n.
REQ-031 start pulsed at cycles 5 and 20 during a HALF=4 transfer -> both ignored; exactly 8 sck rises; one done pulse.
REQ-032 reset asserted at cycle 30 of a transfer -> sck=0 and cs_n=1 within the same cycle; busy=0; the next start gives a full, correct byte.
REQ-033 Both builds, HALF=3, miso changes only on sck falls, pattern 8'h81 -> rx_data=8'h81 in both builds; done cycle identical between builds.
